// File: rtl/hmmm_pkg.sv
// Shared types, instruction field positions and helpers for the HMMM core.
package hmmm_pkg;

  typedef enum logic [3:0] {
    OP_HALT   = 4'h0,
    OP_SETN   = 4'h1,
    OP_ADDN   = 4'h2,
    OP_COPY   = 4'h3,
    OP_ADD    = 4'h4,
    OP_SUB    = 4'h5,
    OP_NEG    = 4'h6,
    OP_LOADN  = 4'h7,
    OP_STOREN = 4'h8,
    OP_LOADR  = 4'h9,
    OP_STORER = 4'hA,
    OP_JUMPN  = 4'hB,
    OP_JEQZN  = 4'hC,
    OP_JNEZN  = 4'hD,
    OP_JGTZN  = 4'hE,
    OP_JLTZN  = 4'hF
  } opcode_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_EXEC,
    ST_MEM,
    ST_HALT
  } state_t;

  localparam int unsigned OP_MSB  = 15;
  localparam int unsigned OP_LSB  = 12;
  localparam int unsigned RD_MSB  = 11;
  localparam int unsigned RD_LSB  = 8;
  localparam int unsigned RA_MSB  = 7;
  localparam int unsigned RA_LSB  = 4;
  localparam int unsigned RB_MSB  = 3;
  localparam int unsigned RB_LSB  = 0;
  localparam int unsigned IMM_MSB = 7;
  localparam int unsigned IMM_LSB = 0;

  // Sign-extend imm8 to 32 bits; callers truncate to DATA_W, which also
  // covers the DATA_W < 8 case (plain truncation).
  function automatic logic [31:0] sext_imm(input logic [7:0] imm);
    return {{24{imm[7]}}, imm};
  endfunction

endpackage

// File: rtl/hmmm_regfile.sv
// Register file: two async read ports, one sync write port, r0 fixed at 0.
// Indices at or above NREG read as 0 and ignore writes.
module hmmm_regfile
  import hmmm_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned NREG   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        rd1_idx,
  output logic [DATA_W-1:0] rd1_data,
  input  logic [3:0]        rd2_idx,
  output logic [DATA_W-1:0] rd2_data,
  input  logic              wr_en,
  input  logic [3:0]        wr_idx,
  input  logic [DATA_W-1:0] wr_data
);

  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];

  // Read ports: out-of-range and r0 return zero.
  always_comb begin
    rd1_data = '0;
    rd2_data = '0;
    for (int unsigned i = 1; i < NREG; i++) begin
      if (32'(rd1_idx) == i) rd1_data = regs_q[i];
      if (32'(rd2_idx) == i) rd2_data = regs_q[i];
    end
  end

  // Next register contents: single write, r0 and out-of-range discarded.
  always_comb begin
    regs_d = regs_q;
    regs_d[0] = '0;
    for (int unsigned i = 1; i < NREG; i++) begin
      if (wr_en && 32'(wr_idx) == i) regs_d[i] = wr_data;
    end
  end

  // Register storage, cleared on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

endmodule

// File: rtl/hmmm_core.sv
// Multi-cycle HMMM core: FETCH/EXEC/MEM sequencing with req/ack memories.
module hmmm_core
  import hmmm_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned PC_W   = 8,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned NREG   = 16
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_ack,
  input  logic [15:0]       imem_rdata,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              halted,
  output logic [PC_W-1:0]   pc
);

  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [15:0]       ir_q, ir_d;
  logic              dmem_we_q, dmem_we_d;
  logic [ADDR_W-1:0] dmem_addr_q, dmem_addr_d;
  logic [DATA_W-1:0] dmem_wdata_q, dmem_wdata_d;

  opcode_t           op;
  logic [3:0]        rd_f, ra_f, rb_f;
  logic [7:0]        imm;
  logic [DATA_W-1:0] imm_s;
  logic [PC_W-1:0]   target, pc_inc;
  logic              uses_rd;
  logic [3:0]        p1_idx, p2_idx;
  logic [DATA_W-1:0] p1_data, p2_data;
  logic              wr_en;
  logic [3:0]        wr_idx;
  logic [DATA_W-1:0] wr_data;

  assign op     = opcode_t'(ir_q[OP_MSB:OP_LSB]);
  assign rd_f   = ir_q[RD_MSB:RD_LSB];
  assign ra_f   = ir_q[RA_MSB:RA_LSB];
  assign rb_f   = ir_q[RB_MSB:RB_LSB];
  assign imm    = ir_q[IMM_MSB:IMM_LSB];
  assign imm_s  = DATA_W'(sext_imm(imm));
  assign target = PC_W'(imm);
  assign pc_inc = pc_q + PC_W'(1);

  // Port 1 carries rd for ops that read it (ADDN, stores, branches), else ra;
  // port 2 carries ra for register-addressed memory ops, else rb.
  assign uses_rd = op inside {OP_ADDN, OP_STOREN, OP_STORER,
                              OP_JEQZN, OP_JNEZN, OP_JGTZN, OP_JLTZN};
  assign p1_idx  = uses_rd ? rd_f : ra_f;
  assign p2_idx  = (op == OP_LOADR || op == OP_STORER) ? ra_f : rb_f;

  hmmm_regfile #(
    .DATA_W (DATA_W),
    .NREG   (NREG)
  ) u_rf (
    .clk      (clk),
    .reset    (reset),
    .rd1_idx  (p1_idx),
    .rd1_data (p1_data),
    .rd2_idx  (p2_idx),
    .rd2_data (p2_data),
    .wr_en    (wr_en),
    .wr_idx   (wr_idx),
    .wr_data  (wr_data)
  );

  assign imem_req   = (state_q == ST_FETCH);
  assign imem_addr  = pc_q;
  assign dmem_req   = (state_q == ST_MEM);
  assign dmem_we    = dmem_we_q;
  assign dmem_addr  = dmem_addr_q;
  assign dmem_wdata = dmem_wdata_q;
  assign halted     = (state_q == ST_HALT);
  assign pc         = pc_q;

  // Next-state, PC, instruction latch, ALU, branch decision and reg write.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ir_d         = ir_q;
    dmem_we_d    = dmem_we_q;
    dmem_addr_d  = dmem_addr_q;
    dmem_wdata_d = dmem_wdata_q;
    wr_en        = 1'b0;
    wr_idx       = rd_f;
    wr_data      = '0;
    case (state_q)
      ST_IDLE:  state_d = ST_FETCH;
      ST_FETCH: begin
        if (imem_ack) begin
          ir_d    = imem_rdata;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        state_d = ST_FETCH;
        pc_d    = pc_inc;
        case (op)
          OP_HALT: begin
            state_d = ST_HALT;
            pc_d    = pc_q;
          end
          OP_SETN: begin wr_en = 1'b1; wr_data = imm_s;             end
          OP_ADDN: begin wr_en = 1'b1; wr_data = p1_data + imm_s;   end
          OP_COPY: begin wr_en = 1'b1; wr_data = p1_data;           end
          OP_ADD:  begin wr_en = 1'b1; wr_data = p1_data + p2_data; end
          OP_SUB:  begin wr_en = 1'b1; wr_data = p1_data - p2_data; end
          OP_NEG:  begin wr_en = 1'b1; wr_data = '0 - p1_data;      end
          OP_LOADN, OP_STOREN, OP_LOADR, OP_STORER: begin
            state_d      = ST_MEM;
            dmem_we_d    = (op == OP_STOREN || op == OP_STORER);
            dmem_addr_d  = (op == OP_LOADN || op == OP_STOREN) ? ADDR_W'(imm)
                                                               : ADDR_W'(p2_data);
            dmem_wdata_d = p1_data;
          end
          OP_JUMPN: pc_d = target;
          OP_JEQZN: if (p1_data == '0) pc_d = target;
          OP_JNEZN: if (p1_data != '0) pc_d = target;
          OP_JGTZN: if (!p1_data[DATA_W-1] && p1_data != '0) pc_d = target;
          OP_JLTZN: if (p1_data[DATA_W-1]) pc_d = target;
          default: ;
        endcase
      end
      ST_MEM: begin
        if (dmem_ack) begin
          state_d = ST_FETCH;
          if (!dmem_we_q) begin
            wr_en   = 1'b1;
            wr_data = dmem_rdata;
          end
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
  end

  // Core state registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      pc_q         <= '0;
      ir_q         <= '0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= '0;
      dmem_wdata_q <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ir_q         <= ir_d;
      dmem_we_q    <= dmem_we_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_wdata_q <= dmem_wdata_d;
    end
  end

endmodule

// File: tb/tb_hmmm_core.sv
// Directed bench for hmmm_core with zero-wait imem and delayable dmem.
module tb_hmmm_core;

  logic        clk;
  logic        reset;
  logic        imem_req, imem_ack;
  logic [7:0]  imem_addr;
  logic [15:0] imem_rdata;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [7:0]  dmem_addr, dmem_wdata, dmem_rdata;
  logic        halted;
  logic [7:0]  pc;

  logic        d4_imem_req, d4_dmem_req, d4_dmem_we, d4_halted;
  logic [7:0]  d4_imem_addr, d4_dmem_addr, d4_pc;
  logic [15:0] d4_imem_rdata;
  logic [3:0]  d4_dmem_wdata;

  logic [15:0] rom [256];
  logic [7:0]  dmem [256];
  bit          dvalid [256];
  int          dcnt;
  int          ddly;
  logic        dack_man, dack_val;

  int total = 0;
  int bad   = 0;
  int n, c, mc, errs;
  logic [7:0] br_v   [3];
  logic [7:0] br_exp [12];

  hmmm_core #(.DATA_W(8), .PC_W(8), .ADDR_W(8), .NREG(16)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .halted(halted), .pc(pc)
  );

  hmmm_core #(.DATA_W(4), .PC_W(8), .ADDR_W(8), .NREG(16)) dut4 (
    .clk(clk), .reset(reset),
    .imem_req(d4_imem_req), .imem_addr(d4_imem_addr), .imem_ack(d4_imem_req), .imem_rdata(d4_imem_rdata),
    .dmem_req(d4_dmem_req), .dmem_we(d4_dmem_we), .dmem_addr(d4_dmem_addr), .dmem_wdata(d4_dmem_wdata),
    .dmem_ack(d4_dmem_req), .dmem_rdata(4'h0),
    .halted(d4_halted), .pc(d4_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign imem_ack      = imem_req;
  assign imem_rdata    = rom[imem_addr];
  assign d4_imem_rdata = rom[d4_imem_addr];
  assign dmem_ack      = dack_man ? dack_val : (dmem_req && dcnt >= ddly);
  assign dmem_rdata    = dvalid[dmem_addr] ? dmem[dmem_addr] : (dmem_addr ^ 8'hA5);

  always @(posedge clk) begin
    dcnt <= (dmem_req && !dmem_ack) ? dcnt + 1 : 0;
    if (dmem_req && dmem_ack && dmem_we) begin
      dmem[dmem_addr]   <= dmem_wdata;
      dvalid[dmem_addr] <= 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_rom;
    for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
  endtask

  task automatic apply_reset;
    reset    = 1'b1;
    dack_man = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run_to_halt(output int cyc);
    cyc = 0;
    while (!halted && cyc < 200) begin
      step();
      cyc++;
    end
  endtask

  task automatic wait_fetch(input logic [7:0] a, output int cyc);
    cyc = 0;
    while (!(imem_req && imem_addr == a) && cyc < 100) begin
      step();
      cyc++;
    end
  endtask

  initial begin
    reset    = 1'b1;
    dack_man = 1'b0;
    dack_val = 1'b0;
    ddly     = 0;
    br_v     = '{8'hFF, 8'h00, 8'h01};
    // JEQZN, JNEZN, JGTZN, JLTZN each against r1 = -1, 0, +1
    br_exp   = '{8'h02, 8'h40, 8'h02,
                 8'h40, 8'h02, 8'h40,
                 8'h02, 8'h02, 8'h40,
                 8'h40, 8'h02, 8'h02};

    // Reset values
    clear_rom();
    rom[0] = 16'h1105; // SETN r1,5
    rom[1] = 16'h21FE; // ADDN r1,-2
    rom[2] = 16'h0000; // HALT
    #2;
    chk("rst_imem_req", imem_req, 0);
    chk("rst_dmem_req", dmem_req, 0);
    chk("rst_dmem_we", dmem_we, 0);
    chk("rst_dmem_addr", dmem_addr, 0);
    chk("rst_dmem_wdata", dmem_wdata, 0);
    chk("rst_halted", halted, 0);
    chk("rst_pc", pc, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("idle_no_req", imem_req, 0);
    step();
    chk("first_fetch_req", imem_req, 1);
    run_to_halt(n);
    chk("halt_cycle", n, 6);
    chk("t1_r1", dut.u_rf.regs_q[1], 8'h03);
    chk("t1_pc", pc, 8'h02);
    errs = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (imem_req !== 1'b0 || halted !== 1'b1) errs++;
    end
    chk("t1_sticky_halt_noreq", errs, 0);

    // SUB wrap, DATA_W 8 and 4
    clear_rom();
    rom[0] = 16'h1107; // SETN r1,7
    rom[1] = 16'h1209; // SETN r2,9
    rom[2] = 16'h5312; // SUB r3,r1,r2
    apply_reset();
    run_to_halt(n);
    step();
    chk("sub_w8", dut.u_rf.regs_q[3], 8'hFE);
    chk("sub_w4", dut4.u_rf.regs_q[3], 4'hE);
    chk("sub_w4_halt", d4_halted, 1);

    // Store/load with 3 wait cycles on dmem_ack
    clear_rom();
    rom[0] = 16'h135A; // SETN r3,0x5A
    rom[1] = 16'h8320; // STOREN r3,0x20
    rom[2] = 16'h7420; // LOADN r4,0x20
    ddly = 3;
    apply_reset();
    wait_fetch(8'h01, n);
    c = 0; mc = 0; errs = 0;
    while (!(imem_req && imem_addr == 8'h02) && c < 40) begin
      step();
      c++;
      if (dmem_req) begin
        mc++;
        if (dmem_addr !== 8'h20 || dmem_we !== 1'b1 || dmem_wdata !== 8'h5A) errs++;
      end
    end
    chk("store_cycles", c, 6);
    chk("store_mem_cycles", mc, 4);
    chk("store_stable", errs, 0);
    c = 0; mc = 0; errs = 0;
    while (!(imem_req && imem_addr == 8'h03) && c < 40) begin
      step();
      c++;
      if (dmem_req) begin
        mc++;
        if (dmem_addr !== 8'h20 || dmem_we !== 1'b0) errs++;
      end
    end
    chk("load_cycles", c, 6);
    chk("load_mem_cycles", mc, 4);
    chk("load_stable", errs, 0);
    run_to_halt(n);
    chk("load_r4", dut.u_rf.regs_q[4], 8'h5A);
    ddly = 0;

    // Conditional branches
    for (int k = 0; k < 4; k++) begin
      for (int v = 0; v < 3; v++) begin
        clear_rom();
        rom[0] = {8'h11, br_v[v]};
        rom[1] = {4'(12 + k), 4'h1, 8'h40};
        apply_reset();
        run_to_halt(n);
        chk($sformatf("branch_op%0h_v%0h", 12 + k, br_v[v]), pc, br_exp[k*3 + v]);
      end
    end

    // r0 hard-wired zero
    clear_rom();
    rom[0] = 16'h1009; // SETN r0,9
    rom[1] = 16'h3100; // COPY r1,r0
    apply_reset();
    run_to_halt(n);
    chk("r0_copy", dut.u_rf.regs_q[1], 8'h00);

    // PC wrap
    clear_rom();
    rom[0]     = 16'hB0FF; // JUMPN 0xFF
    rom[8'hFF] = 16'h2201; // ADDN r2,1
    apply_reset();
    wait_fetch(8'hFF, n);
    chk("wrap_reach_ff", imem_addr, 8'hFF);
    step();
    step();
    chk("wrap_req", imem_req, 1);
    chk("wrap_addr", imem_addr, 8'h00);
    chk("wrap_r2", dut.u_rf.regs_q[2], 8'h01);

    // Reset while a load waits on dmem_ack
    clear_rom();
    rom[0] = 16'h1611; // SETN r6,0x11
    rom[1] = 16'h7530; // LOADN r5,0x30
    ddly = 1000;
    apply_reset();
    n = 0;
    while (!dmem_req && n < 50) begin
      step();
      n++;
    end
    chk("mid_wait_req", dmem_req, 1);
    step();
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_dreq", dmem_req, 0);
    chk("mid_rst_ireq", imem_req, 0);
    chk("mid_rst_daddr", dmem_addr, 0);
    chk("mid_rst_r6", dut.u_rf.regs_q[6], 0);
    @(negedge clk);
    reset = 1'b0;
    ddly  = 0;
    step();
    dack_man = 1'b1;
    dack_val = 1'b1;
    chk("mid_refetch_req", imem_req, 1);
    chk("mid_refetch_addr", imem_addr, 8'h00);
    step();
    dack_man = 1'b0;
    dack_val = 1'b0;
    chk("mid_ack_ignored", dmem_req, 0);
    chk("mid_ack_pc", pc, 8'h00);
    chk("mid_ack_r5", dut.u_rf.regs_q[5], 8'h00);
    run_to_halt(n);
    chk("mid_final_r6", dut.u_rf.regs_q[6], 8'h11);
    chk("mid_final_r5", dut.u_rf.regs_q[5], 8'h95);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
